// File: rtl/racl_err_log_collector.sv
// racl_err_log_collector: consumer end of the RACL error-log interface.
// Buffers valid error records in a circular FIFO and hands them to a
// valid/ready reader. Records lost to a full FIFO set a sticky flag and
// bump a saturating drop counter.
// Optional feature: define RACL_LOG_TIMESTAMP_EN to store a 16-bit cycle
// timestamp with each entry (log_ts_o); otherwise log_ts_o is tied to 0.
module racl_err_log_collector #(
  parameter int DEPTH  = 4,
  parameter int DROP_W = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [33:0]              err_log_i,
  output logic                     log_valid_o,
  input  logic                     log_ready_i,
  output logic [31:0]              log_addr_o,
  output logic                     log_ovf_o,
  output logic [15:0]              log_ts_o,
  output logic [$clog2(DEPTH):0]   count_o,
  input  logic                     clr_i,
  output logic                     ovf_sticky_o,
  output logic [DROP_W-1:0]        drop_cnt_o,
  output logic                     irq_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [31:0]       mem_addr [DEPTH];
  logic [DEPTH-1:0]  mem_ovf;
  logic [AW-1:0]     rd_ptr;
  logic [AW-1:0]     wr_ptr;
  logic [CW-1:0]     count;
  logic              ovf_sticky;
  logic [DROP_W-1:0] drop_cnt;

  logic              push_req;
  logic              pop;
  logic              push_ok;
  logic              drop;
  logic              full;

`ifdef RACL_LOG_TIMESTAMP_EN
  logic [15:0]       ts_cnt;
  logic [15:0]       mem_ts [DEPTH];
`endif

  // Handshake decode: a full FIFO still accepts a push when a pop frees the slot.
  always_comb begin
    push_req = err_log_i[1];
    full     = (count == CW'(DEPTH));
    pop      = 1'b0;
    push_ok  = 1'b0;
    drop     = 1'b0;
    if (count != {CW{1'b0}}) begin
      pop = log_ready_i;
    end else begin
      pop = 1'b0;
    end
    if (push_req) begin
      push_ok = !full || pop;
      drop    = full && !pop;
    end else begin
      push_ok = 1'b0;
      drop    = 1'b0;
    end
  end

  // Entry storage; contents need no reset because head outputs are gated by occupancy.
  always_ff @(posedge clk_i) begin
    if (!rst_i && push_ok) begin
      mem_addr[wr_ptr] <= err_log_i[33:2];
      mem_ovf[wr_ptr]  <= err_log_i[0];
`ifdef RACL_LOG_TIMESTAMP_EN
      mem_ts[wr_ptr]   <= ts_cnt;
`endif
    end
  end

  // Pointers wrap naturally (DEPTH is a power of two); occupancy tracked separately.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_ptr <= {AW{1'b0}};
      wr_ptr <= {AW{1'b0}};
      count  <= {CW{1'b0}};
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (push_ok && !pop) begin
        count <= count + CW'(1);
      end else if (pop && !push_ok) begin
        count <= count - CW'(1);
      end
    end
  end

  // Loss tracking: a clear applies before a same-cycle drop or producer overflow.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ovf_sticky <= 1'b0;
      drop_cnt   <= {DROP_W{1'b0}};
    end else begin
      ovf_sticky <= (ovf_sticky && !clr_i) || drop || (push_req && err_log_i[0]);
      if (clr_i) begin
        drop_cnt <= drop ? DROP_W'(1) : {DROP_W{1'b0}};
      end else if (drop && (drop_cnt != {DROP_W{1'b1}})) begin
        drop_cnt <= drop_cnt + DROP_W'(1);
      end
    end
  end

`ifdef RACL_LOG_TIMESTAMP_EN
  // Free-running cycle counter sampled into each entry at its push edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ts_cnt <= 16'd0;
    end else begin
      ts_cnt <= ts_cnt + 16'd1;
    end
  end
`endif

  // Head and status outputs, all derived from registers only.
  always_comb begin
    log_valid_o  = (count != {CW{1'b0}});
    log_addr_o   = 32'd0;
    log_ovf_o    = 1'b0;
    log_ts_o     = 16'd0;
    if (log_valid_o) begin
      log_addr_o = mem_addr[rd_ptr];
      log_ovf_o  = mem_ovf[rd_ptr];
`ifdef RACL_LOG_TIMESTAMP_EN
      log_ts_o   = mem_ts[rd_ptr];
`else
      log_ts_o   = 16'd0;
`endif
    end else begin
      log_addr_o = 32'd0;
      log_ovf_o  = 1'b0;
      log_ts_o   = 16'd0;
    end
    count_o      = count;
    ovf_sticky_o = ovf_sticky;
    drop_cnt_o   = drop_cnt;
    irq_o        = log_valid_o | ovf_sticky;
  end

endmodule

// File: tb/tb_racl_err_log_collector.sv
// Scoreboard bench for racl_err_log_collector (DEPTH=4, DROP_W=8).
// Stimulus pushes expected records into a queue; a negedge monitor pops and
// compares whenever the DUT completes a valid/ready transfer.
module tb_racl_err_log_collector;

  localparam int DEPTH  = 4;
  localparam int DROP_W = 8;
  localparam int DMAX   = (1 << DROP_W) - 1;

  typedef struct {
    logic [31:0] addr;
    logic        ovf;
    logic [15:0] ts;
  } rec_t;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [33:0] err_log_i;
  logic        log_valid_o;
  logic        log_ready_i;
  logic [31:0] log_addr_o;
  logic        log_ovf_o;
  logic [15:0] log_ts_o;
  logic [2:0]  count_o;
  logic        clr_i;
  logic        ovf_sticky_o;
  logic [7:0]  drop_cnt_o;
  logic        irq_o;

  racl_err_log_collector #(.DEPTH(DEPTH), .DROP_W(DROP_W)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .err_log_i(err_log_i),
    .log_valid_o(log_valid_o), .log_ready_i(log_ready_i),
    .log_addr_o(log_addr_o), .log_ovf_o(log_ovf_o), .log_ts_o(log_ts_o),
    .count_o(count_o), .clr_i(clr_i), .ovf_sticky_o(ovf_sticky_o),
    .drop_cnt_o(drop_cnt_o), .irq_o(irq_o)
  );

  always #5 clk_i = ~clk_i;

  int   vectors = 0;
  int   miscompares = 0;
  rec_t exp_q[$];

  // Reference state, from the behavioural rules only.
  int   cnt_m = 0;
  int   drop_m = 0;
  bit   sticky_m = 1'b0;
  int   ts_m = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every completed transfer must match the oldest expected record.
  always @(negedge clk_i) begin
    if (rst_i === 1'b0 && log_valid_o === 1'b1 && log_ready_i === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("pop_unexpected", 32'd1, 32'd0);
      end else begin
        chk("pop_addr", log_addr_o, exp_q[0].addr);
        chk("pop_ovf", {31'd0, log_ovf_o}, {31'd0, exp_q[0].ovf});
        chk("pop_ts", {16'd0, log_ts_o}, {16'd0, exp_q[0].ts});
        void'(exp_q.pop_front());
      end
    end
  end

  // One clock of stimulus: drive, check registered status, then advance model.
  task automatic cycle(input bit push, input logic [31:0] addr, input bit ovf,
                       input bit ready, input bit clr, input bit rst);
    bit   pop;
    bit   acc;
    bit   drp;
    rec_t r;
    err_log_i   = {addr, push, ovf};
    log_ready_i = ready;
    clr_i       = clr;
    rst_i       = rst;
    @(negedge clk_i);
    chk("count", {29'd0, count_o}, cnt_m);
    chk("valid", {31'd0, log_valid_o}, (cnt_m > 0) ? 32'd1 : 32'd0);
    chk("drop_cnt", {24'd0, drop_cnt_o}, drop_m);
    chk("sticky", {31'd0, ovf_sticky_o}, {31'd0, sticky_m});
    chk("irq", {31'd0, irq_o}, ((cnt_m > 0) || sticky_m) ? 32'd1 : 32'd0);
    if (cnt_m == 0) begin
      chk("idle_head", {log_addr_o[30:0], log_ovf_o} | {16'd0, log_ts_o}, 32'd0);
    end
    pop = ready && (cnt_m > 0);
    acc = push && ((cnt_m < DEPTH) || pop);
    drp = push && !acc;
    @(posedge clk_i);
    if (rst) begin
      cnt_m = 0; drop_m = 0; sticky_m = 1'b0; ts_m = 0;
      exp_q.delete();
    end else begin
      if (acc) begin
        r.addr = addr;
        r.ovf  = ovf;
`ifdef RACL_LOG_TIMESTAMP_EN
        r.ts   = 16'(ts_m);
`else
        r.ts   = 16'd0;
`endif
        exp_q.push_back(r);
      end
      cnt_m = cnt_m + (acc ? 1 : 0) - (pop ? 1 : 0);
      if (clr) begin
        drop_m   = 0;
        sticky_m = 1'b0;
      end
      if (drp) drop_m = (drop_m < DMAX) ? drop_m + 1 : DMAX;
      if (drp || (push && ovf)) sticky_m = 1'b1;
      ts_m = (ts_m + 1) % 65536;
    end
    #1;
  endtask

  initial begin
    rst_i = 1'b1; err_log_i = 34'd0; log_ready_i = 1'b0; clr_i = 1'b0;
    @(posedge clk_i);
    #1;
    cycle(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    // Reset state observed, then single push visible one cycle later.
    cycle(1'b1, 32'h1000_0040, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t1_head", log_addr_o, 32'h1000_0040);
    cycle(1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t1_irq_low", {31'd0, irq_o}, 32'd0);

    // Overfill: six pushes into four slots, then drain in order.
    for (int i = 0; i < 6; i++) cycle(1'b1, 32'(i), 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t2_drops", {24'd0, drop_cnt_o}, 32'd2);
    for (int i = 0; i < 4; i++) cycle(1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Full FIFO: simultaneous push and pop is not a drop.
    for (int i = 0; i < 4; i++) cycle(1'b1, 32'h10 + 32'(i), 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 32'hAA, 1'b0, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t3_count", {29'd0, count_o}, 32'd4);
    for (int i = 0; i < 4; i++) cycle(1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0);

    // Saturation, then clear coinciding with one more drop.
    for (int i = 0; i < 4; i++) cycle(1'b1, 32'h200 + 32'(i), 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 300; i++) cycle(1'b1, 32'h300, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t4_sat", {24'd0, drop_cnt_o}, 32'hFF);
    cycle(1'b1, 32'h301, 1'b0, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0);

    // Producer overflow bit stored; invalid record ignored.
    cycle(1'b1, 32'h400, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 32'h401, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("t5_head_ovf", {31'd0, log_ovf_o}, 32'd1);
    cycle(1'b0, 32'h402, 1'b1, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset with three entries buffered and a push pending.
    for (int i = 0; i < 3; i++) cycle(1'b1, 32'h500 + 32'(i), 1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 32'h5FF, 1'b0, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 32'h600, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0);

    // Randomised traffic against the reference model.
    for (int i = 0; i < 1500; i++) begin
      cycle(($urandom_range(0, 2) != 0), $urandom, ($urandom_range(0, 7) == 0),
            ($urandom_range(0, 2) == 0), ($urandom_range(0, 31) == 0),
            ($urandom_range(0, 199) == 0));
    end

    // Drain and confirm nothing expected is left behind.
    for (int i = 0; i < 2 * DEPTH; i++) cycle(1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("drain_queue", exp_q.size(), 32'd0);
    chk("drain_count", {29'd0, count_o}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
